// File: rtl/mux_scan_n.sv
// mux_scan_n: multi-channel registered 2^SEL_BITS-to-1 selector with a built-in scan counter.
//
// Each channel picks one of NIN = 2^SEL_BITS words, using either the external select S
// (MODE=0) or the internal scan counter SEL_Q (MODE=1). The picked word is registered
// on CE. A per-channel active-low enable forces that channel's output word to zero.
//
// Ports:
//   CLK    system clock, rising edge
//   RST    synchronous active-high reset
//   CE     clock enable: output register update and scan advance
//   MODE   0 = select from S, 1 = select from scan counter
//   LOAD   load scan counter from S (has priority over advance)
//   S      external select
//   nE     per-channel active-low enable
//   I      data; channel c, input n at ((c*NIN+n)*WIDTH)+:WIDTH
//   Z      registered outputs; channel c at c*WIDTH+:WIDTH
//   SEL_Q  current scan counter value
//   WRAP   one-cycle pulse after the counter advances from NIN-1 to 0
//   VALID  high the cycle after any CE=1 cycle
module mux_scan_n #(
    parameter int unsigned WIDTH    = 1,
    parameter int unsigned SEL_BITS = 2,
    parameter int unsigned CHANNELS = 2
) (
    input  logic                                     CLK,
    input  logic                                     RST,
    input  logic                                     CE,
    input  logic                                     MODE,
    input  logic                                     LOAD,
    input  logic [SEL_BITS-1:0]                      S,
    input  logic [CHANNELS-1:0]                      nE,
    input  logic [CHANNELS*(2**SEL_BITS)*WIDTH-1:0]  I,
    output logic [CHANNELS*WIDTH-1:0]                Z,
    output logic [SEL_BITS-1:0]                      SEL_Q,
    output logic                                     WRAP,
    output logic                                     VALID
);

    localparam int unsigned NIN = 2 ** SEL_BITS;

    logic [CHANNELS*WIDTH-1:0] z_q, z_d;
    logic [SEL_BITS-1:0]       sel_q, sel_d;
    logic                      wrap_q, wrap_d;
    logic                      valid_q, valid_d;
    logic [SEL_BITS-1:0]       esel;

    // Select uses the pre-edge counter, so a LOAD on the same edge does not affect Z.
    assign esel = MODE ? sel_q : S;

    always_comb begin
        z_d = z_q;
        if (CE) begin
            for (int unsigned c = 0; c < CHANNELS; c++) begin
                if (nE[c]) begin
                    z_d[c*WIDTH +: WIDTH] = '0;
                end else begin
                    z_d[c*WIDTH +: WIDTH] = I[(c*NIN + 32'(esel))*WIDTH +: WIDTH];
                end
            end
        end
    end

    always_comb begin
        sel_d  = sel_q;
        wrap_d = 1'b0;
        if (LOAD) begin
            sel_d = S;
        end else if (MODE && CE) begin
            // Natural wrap at SEL_BITS width gives mod NIN.
            sel_d  = sel_q + 1'b1;
            wrap_d = &sel_q;
        end
        valid_d = CE;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            z_q     <= '0;
            sel_q   <= '0;
            wrap_q  <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            z_q     <= z_d;
            sel_q   <= sel_d;
            wrap_q  <= wrap_d;
            valid_q <= valid_d;
        end
    end

    assign Z     = z_q;
    assign SEL_Q = sel_q;
    assign WRAP  = wrap_q;
    assign VALID = valid_q;

endmodule

// File: tb/tb_mux_scan_n.sv
// tb_mux_scan_n: directed-vector bench for mux_scan_n (WIDTH=4, SEL_BITS=2, CHANNELS=2).
module tb_mux_scan_n;

    logic        CLK = 1'b0;
    logic        RST, CE, MODE, LOAD;
    logic [1:0]  S;
    logic [1:0]  nE;
    logic [31:0] I;
    logic [7:0]  Z;
    logic [1:0]  SEL_Q;
    logic        WRAP, VALID;

    int n_cmp = 0;
    int n_err = 0;

    mux_scan_n #(
        .WIDTH    (4),
        .SEL_BITS (2),
        .CHANNELS (2)
    ) dut (
        .CLK   (CLK),
        .RST   (RST),
        .CE    (CE),
        .MODE  (MODE),
        .LOAD  (LOAD),
        .S     (S),
        .nE    (nE),
        .I     (I),
        .Z     (Z),
        .SEL_Q (SEL_Q),
        .WRAP  (WRAP),
        .VALID (VALID)
    );

    always #5 CLK = ~CLK;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one edge; outputs are sampled 1ns later.
    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic check_all(input string tag, input logic [7:0] ez, input logic [1:0] es,
                             input logic ew, input logic ev);
        check_eq({tag, ".Z"}, 32'(Z), 32'(ez));
        check_eq({tag, ".SEL_Q"}, 32'(SEL_Q), 32'(es));
        check_eq({tag, ".WRAP"}, 32'(WRAP), 32'(ew));
        check_eq({tag, ".VALID"}, 32'(VALID), 32'(ev));
    endtask

    logic [7:0] scan_z [5] = '{8'hA1, 8'hB2, 8'hC3, 8'hD4, 8'hA1};
    logic [1:0] scan_s [5] = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
    logic       scan_w [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    logic [7:0] en_z   [4] = '{8'hB0, 8'hC0, 8'hD0, 8'hA0};
    logic [1:0] en_s   [4] = '{2'd2, 2'd3, 2'd0, 2'd1};
    logic       en_w   [4] = '{1'b0, 1'b0, 1'b1, 1'b0};

    initial begin
        I    = 32'hDCBA_4321;
        nE   = 2'b00;
        MODE = 1'b0;

        // Reset overrides CE and LOAD.
        RST = 1'b1; CE = 1'b1; LOAD = 1'b1; S = 2'd3;
        step();
        check_all("reset", 8'h00, 2'd0, 1'b0, 1'b0);
        RST = 1'b0; LOAD = 1'b0;

        // Direct select, then hold with CE=0.
        CE = 1'b1; S = 2'd2;
        step();
        check_all("direct", 8'hC3, 2'd0, 1'b0, 1'b1);
        CE = 1'b0; S = 2'd1;
        step();
        check_all("hold", 8'hC3, 2'd0, 1'b0, 1'b0);

        // Scan from SEL_Q=0.
        MODE = 1'b1; CE = 1'b1;
        for (int k = 0; k < 5; k++) begin
            step();
            check_all($sformatf("scan%0d", k), scan_z[k], scan_s[k], scan_w[k], 1'b1);
        end

        // Channel 0 disabled; counter continues from 1.
        nE = 2'b01;
        for (int k = 0; k < 4; k++) begin
            step();
            check_all($sformatf("en%0d", k), en_z[k], en_s[k], en_w[k], 1'b1);
        end
        nE = 2'b00;

        // Load 3 without CE, then LOAD colliding with a scan advance.
        CE = 1'b0; LOAD = 1'b1; S = 2'd3;
        step();
        check_all("load3", 8'hA0, 2'd3, 1'b0, 1'b0);
        CE = 1'b1; S = 2'd1;
        step();
        check_all("ldcoll", 8'hD4, 2'd1, 1'b0, 1'b1);
        LOAD = 1'b0;
        step();
        check_all("postld", 8'hB2, 2'd2, 1'b0, 1'b1);

        // Mid-scan reset at SEL_Q=2, then resume.
        RST = 1'b1;
        step();
        check_all("midrst", 8'h00, 2'd0, 1'b0, 1'b0);
        RST = 1'b0;
        step();
        check_all("resume", 8'hA1, 2'd1, 1'b0, 1'b1);
        step();
        check_all("resume2", 8'hB2, 2'd2, 1'b0, 1'b1);

        // Switch to direct at SEL_Q=2: counter frozen, Z follows S.
        MODE = 1'b0; S = 2'd0;
        step();
        check_all("frz0", 8'hA1, 2'd2, 1'b0, 1'b1);
        S = 2'd3;
        step();
        check_all("frz3", 8'hD4, 2'd2, 1'b0, 1'b1);

        // LOAD with CE in direct mode: Z uses S and counter takes S.
        LOAD = 1'b1; S = 2'd1;
        step();
        check_all("ldmode0", 8'hB2, 2'd1, 1'b0, 1'b1);
        LOAD = 1'b0; CE = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
